// File: rtl/rr_arb_mux_pkg.sv
// Shared constants and helpers for the round-robin arbitrating mux.
// Instances pick WIDTH by name from the datapath-width constants below.
package rr_arb_mux_pkg;

  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned DataWidth    = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned sel_width(input int unsigned num_ch);
    return (num_ch > 1) ? clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between producers/consumer and the arbitrating mux.
// slave is the mux's view; master is the surrounding environment.
interface rr_arb_mux_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_CH = 2
);
  import rr_arb_mux_pkg::*;

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic                    force_en;
  logic [SEL_W-1:0]        force_sel;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, force_en, force_sel, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, force_en, force_sel, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first eligible channel at or after rr_ptr_i.
// Doubled request vector makes the wrap-around scan a plain find-first-one.
module arb_rr_pick #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned SEL_W  = 1
) (
  input  logic [NUM_CH-1:0] eligible_i,
  input  logic [SEL_W-1:0]  rr_ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [SEL_W-1:0]  grant_idx_o
);

  // One extra bit so rr_ptr + offset never overflows before the modulo fix-up.
  localparam int unsigned IdxW = SEL_W + 1;

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rotated;
  logic                found;
  logic [IdxW-1:0]     offset;
  logic [IdxW-1:0]     abs_idx;

  always_comb begin
    doubled = {eligible_i, eligible_i};
    rotated = '0;
    found   = 1'b0;
    offset  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rotated[i] = doubled[int'(rr_ptr_i) + i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = IdxW'(i);
      end
    end
    abs_idx = IdxW'(rr_ptr_i) + offset;
    if (abs_idx >= IdxW'(NUM_CH)) begin
      abs_idx = abs_idx - IdxW'(NUM_CH);
    end
    grant_idx_o = found ? abs_idx[SEL_W-1:0] : '0;
    grant_o     = found ? (NUM_CH'(1) << abs_idx) : '0;
  end

endmodule

// File: rtl/rr_arb_mux.sv
// Registered N-way round-robin arbitrating mux with forced-select override.
// Holds the output register, the priority pointer and the valid/ready handshake.
module rr_arb_mux import rr_arb_mux_pkg::*; #(
  parameter int unsigned WIDTH  = RegAddrWidth,
  parameter int unsigned NUM_CH = 2
) (
  input logic         clk,
  input logic         rst_n,
  rr_arb_mux_if.slave bus
);

  localparam int unsigned SEL_W = sel_width(NUM_CH);

  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [NUM_CH-1:0] in_ready;
  logic              load;
  logic              xfer;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  // An out-of-range force_sel matches no channel, so nothing is eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = bus.in_valid[i] & (~bus.force_en | (int'(bus.force_sel) == i));
    end
  end

  arb_rr_pick #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_pick (
    .eligible_i  (eligible),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_comb begin
    load     = ~out_valid_q | bus.out_ready;
    in_ready = (load & rst_n) ? grant : '0;
    xfer     = |in_ready;

    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;

    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        // Select via the one-hot grant so ungranted channels never reach out_data.
        for (int i = 0; i < NUM_CH; i++) begin
          if (grant[i]) begin
            out_data_d = bus.in_data[i*WIDTH +: WIDTH];
          end
        end
        out_sel_d = grant_idx;
        rr_ptr_d  = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: 2-, 3- and 4-channel instances checked every cycle
// against a behavioural round-robin model, with directed and random stimulus.
module tb_rr_arb_mux;
  import rr_arb_mux_pkg::*;

  localparam int unsigned W    = RegAddrWidth;
  localparam int          NDUT = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rr_arb_mux_if #(.WIDTH(W), .NUM_CH(2)) bus2 ();
  rr_arb_mux_if #(.WIDTH(W), .NUM_CH(3)) bus3 ();
  rr_arb_mux_if #(.WIDTH(W), .NUM_CH(4)) bus4 ();

  rr_arb_mux #(.WIDTH(W), .NUM_CH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  rr_arb_mux #(.WIDTH(W), .NUM_CH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  rr_arb_mux #(.WIDTH(W), .NUM_CH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_checks = 0;
  int n_errors = 0;

  int nch     [NDUT] = '{2, 3, 4};
  int max_sel [NDUT] = '{1, 3, 3};

  // Stimulus per instance
  logic [3:0]   s_valid [NDUT];
  logic [W-1:0] s_data  [NDUT][4];
  logic         s_fen   [NDUT];
  logic [1:0]   s_fsel  [NDUT];
  logic         s_ordy  [NDUT];

  // Reference model state per instance
  logic         m_valid [NDUT];
  logic [W-1:0] m_data  [NDUT];
  int           m_sel   [NDUT];
  int           m_ptr   [NDUT];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus2.in_valid  = s_valid[0][1:0];
    bus2.in_data   = {s_data[0][1], s_data[0][0]};
    bus2.force_en  = s_fen[0];
    bus2.force_sel = s_fsel[0][0];
    bus2.out_ready = s_ordy[0];
    bus3.in_valid  = s_valid[1][2:0];
    bus3.in_data   = {s_data[1][2], s_data[1][1], s_data[1][0]};
    bus3.force_en  = s_fen[1];
    bus3.force_sel = s_fsel[1];
    bus3.out_ready = s_ordy[1];
    bus4.in_valid  = s_valid[2];
    bus4.in_data   = {s_data[2][3], s_data[2][2], s_data[2][1], s_data[2][0]};
    bus4.force_en  = s_fen[2];
    bus4.force_sel = s_fsel[2];
    bus4.out_ready = s_ordy[2];
  endtask

  task automatic get_obs(input int k, output logic [3:0] rdy, output logic ov,
                         output logic [W-1:0] od, output logic [1:0] os);
    case (k)
      0: begin
        rdy = {2'b00, bus2.in_ready}; ov = bus2.out_valid;
        od  = bus2.out_data;          os = {1'b0, bus2.out_sel};
      end
      1: begin
        rdy = {1'b0, bus3.in_ready}; ov = bus3.out_valid;
        od  = bus3.out_data;         os = bus3.out_sel;
      end
      default: begin
        rdy = bus4.in_ready; ov = bus4.out_valid;
        od  = bus4.out_data; os = bus4.out_sel;
      end
    endcase
  endtask

  // Compare against the model, then advance the model by one clock edge.
  task automatic check_and_advance();
    for (int k = 0; k < NDUT; k++) begin
      logic [3:0]   rdy;
      logic         ov;
      logic [W-1:0] od;
      logic [1:0]   os;
      logic [3:0]   exp_rdy;
      bit           load;
      int           g;
      get_obs(k, rdy, ov, od, os);
      load = !m_valid[k] || s_ordy[k];
      g    = -1;
      for (int j = 0; j < nch[k]; j++) begin
        int c;
        c = (m_ptr[k] + j) % nch[k];
        if (g < 0 && s_valid[k][c] && (!s_fen[k] || int'(s_fsel[k]) == c)) g = c;
      end
      exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'h0;
      check_eq($sformatf("n%0d in_ready", nch[k]), 32'(rdy), 32'(exp_rdy));
      check_eq($sformatf("n%0d out_valid", nch[k]), 32'(ov), 32'(m_valid[k]));
      check_eq($sformatf("n%0d out_data", nch[k]), 32'(od), 32'(m_data[k]));
      check_eq($sformatf("n%0d out_sel", nch[k]), 32'(os), 32'(m_sel[k]));
      if (load) begin
        if (g >= 0) begin
          m_valid[k] = 1'b1;
          m_data[k]  = s_data[k][g];
          m_sel[k]   = g;
          m_ptr[k]   = (g + 1) % nch[k];
        end else begin
          m_valid[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_and_advance();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic async_reset();
    logic [3:0]   rdy;
    logic         ov;
    logic [W-1:0] od;
    logic [1:0]   os;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      get_obs(k, rdy, ov, od, os);
      check_eq($sformatf("n%0d rst in_ready", nch[k]), 32'(rdy), 32'h0);
      check_eq($sformatf("n%0d rst out_valid", nch[k]), 32'(ov), 32'h0);
      check_eq($sformatf("n%0d rst out_data", nch[k]), 32'(od), 32'h0);
      check_eq($sformatf("n%0d rst out_sel", nch[k]), 32'(os), 32'h0);
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_sel[k]   = 0;
      m_ptr[k]   = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive();
    #1;
    check_and_advance();
  endtask

  task automatic set_all(input logic [3:0] valid, input logic fen, input logic [1:0] fsel,
                         input logic ordy);
    for (int k = 0; k < NDUT; k++) begin
      s_valid[k] = valid;
      s_fen[k]   = fen;
      s_fsel[k]  = (int'(fsel) > max_sel[k]) ? 2'(max_sel[k]) : fsel;
      s_ordy[k]  = ordy;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 4; i++) s_data[k][i] = W'($urandom);
    end
    set_all(4'h0, 1'b0, 2'd0, 1'b1);
    drive();
    async_reset();

    // Round-robin with all channels valid, then backpressure
    s_data[0][0] = 5'h03;
    s_data[0][1] = 5'h1C;
    set_all(4'hF, 1'b0, 2'd0, 1'b1);
    repeat (6) step();
    set_all(4'hF, 1'b0, 2'd0, 1'b0);
    repeat (3) step();
    set_all(4'hF, 1'b0, 2'd0, 1'b1);
    repeat (4) step();

    // Forced select; on the 3-channel instance force_sel=3 is out of range
    set_all(4'hF, 1'b1, 2'd2, 1'b1);
    repeat (3) step();
    set_all(4'hF, 1'b1, 2'd3, 1'b1);
    repeat (4) step();

    // Mid-stream reset while output is valid, then sparse requests with wrap
    set_all(4'hF, 1'b0, 2'd0, 1'b1);
    step();
    async_reset();
    for (int k = 0; k < NDUT; k++) s_data[k][2] = 5'h15;
    set_all(4'b0100, 1'b0, 2'd0, 1'b1);
    repeat (2) step();
    set_all(4'b0010, 1'b0, 2'd0, 1'b1);
    repeat (2) step();

    // Drain to empty, then a single request
    set_all(4'h0, 1'b0, 2'd0, 1'b1);
    repeat (2) step();
    set_all(4'b0001, 1'b0, 2'd0, 1'b1);
    step();
    set_all(4'h0, 1'b0, 2'd0, 1'b1);
    repeat (2) step();

    // Random traffic with occasional forcing, stalls and resets
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < NDUT; k++) begin
        s_valid[k] = 4'($urandom);
        for (int i = 0; i < 4; i++) s_data[k][i] = W'($urandom);
        s_ordy[k] = ($urandom_range(0, 3) != 0);
        s_fen[k]  = ($urandom_range(0, 7) == 0);
        s_fsel[k] = 2'($urandom_range(0, max_sel[k]));
      end
      if (cyc % 150 == 75) async_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered N-way arbitrating multiplexer; successor to the fixed 2-way 5-bit select mux.
- Routes one of NUM_CH valid/ready input channels of WIDTH bits to a single registered output.
- Uses round-robin arbitration, with an optional forced-select override equivalent to a classic sel-driven mux.
- Used where several producers share one consumer, e.g. instruction-fetch vs. data-access requests to a shared memory port, or register-address sources into a pipeline register.

Parameters:
- WIDTH, 5, data bits per channel.
- NUM_CH, 2, number of input channels (>=1).
- SEL_W, derived localparam = max(1, clog2(NUM_CH)), width of channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i at [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (at most one bit high).
- force_en  input  1  when 1, only channel force_sel is eligible.
- force_sel  input  SEL_W  forced channel index.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of channel that supplied out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - out_valid=0, out_data=0, out_sel=0, priority pointer rr_ptr=0.
  - in_ready=0 while rst_n low.
  - Any in-flight output word is discarded.
- load = ~out_valid | out_ready: the output register may be written this cycle.
- eligible[i] = in_valid[i] & (~force_en | (force_sel == i)).
  - force_sel >= NUM_CH with force_en=1 means no channel is eligible.
- Grant:
  - Combinational; pick the first eligible channel scanning rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - grant is one-hot or zero.
- in_ready[i] = load & grant[i].
  - in_ready may depend on in_valid. Producers must not make in_valid depend on in_ready.
- Transfer occurs on channel g when in_valid[g] & in_ready[g]. On the next edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_CH.
- load=1 with no eligible channel: out_valid <= 0; out_data and out_sel hold their last values.
- load=0 (out_valid & ~out_ready):
  - out_data, out_sel and out_valid are held stable.
  - All in_ready=0; rr_ptr unchanged.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word/cycle with out_ready held high.
- Simultaneous drain and refill (out_valid & out_ready & eligible input): the new word is loaded the same edge with no bubble.
- rr_ptr advances only on a transfer, including transfers made in forced mode. Forced mode does not reset the pointer.
- Fairness: with all channels continuously valid and unforced, each channel is granted exactly once per NUM_CH transfers.
- NUM_CH=1:
  - Block degenerates to a single-entry register slice.
  - out_sel is always 0; force_sel=0 is required when force_en=1, otherwise no grant.
- No X propagation: out_data never takes data from a channel that was not granted.

Decomposition:
- Shared package/header holds:
  - CLOG2 constant function.
  - Default datapath-width constants (5 for register address, 32 for data), so instances pick WIDTH by name.
- One sub-module, arb_rr_pick:
  - Purely combinational.
  - Takes eligible[NUM_CH] and rr_ptr; returns one-hot grant and encoded index.
  - Implemented as double-width rotate + find-first-one.
- The top module holds the output register, rr_ptr and the handshake logic.

Test Plan:
- Reset: WIDTH=5, NUM_CH=2; assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=5'h00, out_sel=0, in_ready=2'b00 immediately; after release, the first grant goes to ch0.
- Round-robin: ch0=5'h03, ch1=5'h1C both always valid, out_ready=1 -> out_valid rises 1 cycle after first transfer; out_data sequence 03,1C,03,1C with out_sel 0,1,0,1; one word per cycle.
- Backpressure: during the above, out_ready=0 for 3 cycles -> out_data/out_sel stable, in_ready=0, rr_ptr frozen; on release the next word comes from the channel after the held one.
- Forced select, NUM_CH=4, all four valid:
  - force_en=1, force_sel=2 -> only ch2 data appears, out_sel=2 every cycle.
  - force_sel=3 -> switches to ch3.
  - force_en=1 with force_sel beyond range (NUM_CH=3, force_sel=3) -> no in_ready, out_valid drops to 0.
- Sparse request: NUM_CH=4, rr_ptr=0, only ch2 valid with data 5'h15 -> granted in the same cycle, out_data=5'h15 next cycle, rr_ptr becomes 3; then only ch1 valid -> granted despite wrap.
- Drain to empty: out_valid=1, out_ready=1, no in_valid -> out_valid=0 next cycle, out_data unchanged; then a single valid input -> out_valid=1 after 1 cycle.
